division: RTL and testbench
===========================

DIVISION -- requirements
Module: division

Interface
REQ-001 The block SHALL have parameters W = 32 (operand/result width) and FRAC = 15 (fraction bits); the numeric format SHALL be signed two's-complement Q17.15.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 a  input  32  dividend, Q17.15 signed.
REQ-005 b  input  32  divisor, Q17.15 signed.
REQ-006 start  input  1  level request; sampled only in IDLE.
REQ-007 res  output  32  quotient, Q17.15 signed; holds last result.
REQ-008 done  output  1  one-cycle pulse when res is updated.
REQ-009 busy  output  1  high from operand capture until the done cycle, inclusive.
REQ-010 dz  output  1  divide-by-zero flag for the last result; updated with res.

Function
REQ-011 The block SHALL compute res = trunc_toward_zero((a * 2^15) / b), i.e. the Q17.15 quotient.
REQ-012 FSM states SHALL be IDLE, RUN, FINISH and HOLD.
REQ-013 In IDLE with start=1, the block SHALL latch a, b, sign = a[31]^b[31], |a| and |b| into internal registers and go to RUN; later changes on a and b SHALL have no effect on the operation in progress.
REQ-014 RUN SHALL perform unsigned restoring division of the 47-bit value |a|<<15 by |b|, producing one quotient bit per cycle MSB first, for exactly 47 cycles.
REQ-015 FINISH SHALL apply the sign, saturate, write res and dz, and pulse done for that one cycle.
REQ-016 Latency: if start is sampled at edge N, res, dz and done SHALL be valid after edge N+48.
REQ-017 After FINISH the FSM SHALL enter HOLD and stay there while start=1; it SHALL return to IDLE when start=0, so a continuously held start yields exactly one operation.
REQ-018 If the unsigned quotient magnitude exceeds 0x7FFFFFFF for a positive result, or 0x80000000 for a negative result, res SHALL saturate to 0x7FFFFFFF or 0x80000000 respectively.
REQ-019 If b = 0, res SHALL be 0x7FFFFFFF when a >= 0 and 0x80000000 when a < 0, with dz = 1; the latency SHALL be unchanged. Otherwise dz SHALL be 0.
REQ-020 |0x80000000| SHALL be handled as the 32-bit unsigned value 2^31 without overflow.
REQ-021 res SHALL remain stable between done pulses.

Reset
REQ-022 While rst=1, asynchronously: FSM = IDLE, res = 0, done = 0, busy = 0, dz = 0, and all datapath registers = 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release the block SHALL accept start normally.

Structure
REQ-024 A shared package division_pkg SHALL hold W, FRAC, the derived dividend width (W+FRAC = 47), the iteration count, and the FSM state enum.
REQ-025 The block SHALL be a single module containing the FSM, the iteration counter, the partial remainder/quotient shift registers, and the sign/saturation logic; no sub-module is required.

Verification
REQ-026 a=0x00028000 (5.0), b=0x00010000 (2.0), start held high -> after 48 cycles res=0x00014000 (2.5), dz=0, exactly one done pulse.
REQ-027 a=0xFFFD8000 (-5.0), b=0x00010000 -> res=0xFFFEC000 (-2.5); and a=0x00008000 (1.0), b=0x00018000 (3.0) -> res=0x00002AAA.
REQ-028 a=0x00028000, b=0 -> res=0x7FFFFFFF, dz=1; a=0xFFFD8000, b=0 -> res=0x80000000, dz=1.
REQ-029 a=0x7FFF8000 (65535.0), b=0x00004000 (0.5) -> res=0x7FFFFFFF (saturated), dz=0.
REQ-030 Assert rst at cycle 20 of an operation -> no done pulse, res=0; a new start after release -> correct result 48 cycles later.
REQ-031 Change a and b during RUN -> result SHALL match the latched operands; busy SHALL stay high throughout RUN.

Source files
------------

// File: rtl/division_pkg.sv
// Shared definitions for the Q17.15 fixed-point divider.
// Holds the operand width, fraction width, derived dividend width,
// iteration count and the FSM state encoding.
package division_pkg;

    localparam int W     = 32;        // operand / result width
    localparam int FRAC  = 15;        // fraction bits (Q17.15)
    localparam int DW    = W + FRAC;  // width of |a| << FRAC (47)
    localparam int ITERS = DW;        // one quotient bit per RUN cycle
    localparam int CNT_W = 6;         // wide enough to count ITERS-1

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/division.sv
// Sequential signed Q17.15 divider: res = trunc_toward_zero((a << 15) / b).
// Operands are captured in IDLE on start, RUN does a 47-step unsigned
// restoring division on magnitudes, FINISH applies sign and saturation,
// HOLD waits for start to drop so a held start gives exactly one operation.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   a     - dividend, Q17.15 signed
//   b     - divisor, Q17.15 signed
//   start - level request, sampled only in IDLE
//   res   - quotient, Q17.15 signed, held until the next done
//   done  - one-cycle pulse when res/dz are updated
//   busy  - high from operand capture through the done cycle
//   dz    - divide-by-zero flag for the last result
//
// Handshake: start is a level request accepted only in IDLE; once accepted,
// a and b are ignored until done. done marks the single cycle in which a
// new res/dz is first visible.
module division
    import division_pkg::*;
#(
    parameter int W    = division_pkg::W,
    parameter int FRAC = division_pkg::FRAC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         start,
    output logic [W-1:0] res,
    output logic         done,
    output logic         busy,
    output logic         dz
);

    localparam int DWL = W + FRAC;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWL - 1);
    // Largest magnitudes representable for positive / negative results.
    localparam logic [DWL-1:0] POS_LIM = {{(FRAC + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [DWL-1:0] NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0]   RES_MAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]   RES_MIN = {1'b1, {(W - 1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             bzero_q, bzero_d;
    logic [DWL-1:0]   dvd_q, dvd_d;    // dividend in, quotient out (shifts left)
    logic [W-1:0]     rem_q, rem_d;    // partial remainder, always < divisor
    logic [W-1:0]     dvs_q, dvs_d;    // divisor magnitude
    logic [W-1:0]     res_q, res_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;

    // Magnitudes as unsigned W-bit values; |most negative| becomes 2^(W-1).
    logic [W-1:0] a_mag, b_mag;
    assign a_mag = a[W-1] ? (~a + 1'b1) : a;
    assign b_mag = b[W-1] ? (~b + 1'b1) : b;

    logic [W:0] trial;
    logic       trial_ge;
    assign trial    = {rem_q, dvd_q[DWL-1]};
    assign trial_ge = (trial >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        bzero_d = bzero_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        dz_d    = dz_q;

        // busy covers the done cycle, then drops.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = a[W-1] ^ b[W-1];
                    bzero_d = (b == '0);
                    dvd_d   = {a_mag, {FRAC{1'b0}}};
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rem_d = trial_ge ? W'(trial - {1'b0, dvs_q}) : trial[W-1:0];
                dvd_d = {dvd_q[DWL-2:0], trial_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (bzero_q) begin
                    // b = 0 so sign_q is just the sign of a.
                    res_d = sign_q ? RES_MIN : RES_MAX;
                    dz_d  = 1'b1;
                end else if (!sign_q) begin
                    res_d = (dvd_q > POS_LIM) ? RES_MAX : dvd_q[W-1:0];
                    dz_d  = 1'b0;
                end else begin
                    res_d = (dvd_q > NEG_LIM) ? RES_MIN : (~dvd_q[W-1:0] + 1'b1);
                    dz_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bzero_q <= 1'b0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            bzero_q <= bzero_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
        end
    end

    assign res  = res_q;
    assign done = done_q;
    assign busy = busy_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_division.sv
module tb_division;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [31:0] res;
    logic        done;
    logic        busy;
    logic        dz;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] last_res = 32'h0;

    division dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .start (start),
        .res   (res),
        .done  (done),
        .busy  (busy),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        total_cnt++;
        if (res !== 32'h0) $display("FAIL reset_res got %h want 00000000", res); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (dz !== 1'b0) $display("FAIL reset_dz got %b want 0", dz); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one operation with start held high for 60 cycles, then drops start.
    // Sample k is taken at the negedge after capture edge N+k.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_res, input logic exp_dz,
                          input string name, input bit scramble);
        int done_cnt;
        int done_at;
        bit busy_ok;
        bit stable_ok;
        done_cnt  = 0;
        done_at   = -1;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k <= 48 && busy !== 1'b1) busy_ok = 1'b0;
            if (k >= 49 && busy !== 1'b0) busy_ok = 1'b0;
            if (k < 48 && res !== last_res) stable_ok = 1'b0;
            if (scramble && k == 10) begin
                a = $urandom;
                b = $urandom_range(1, 32'h7fffffff);
            end
        end
        total_cnt++;
        if (done_at !== 48) $display("FAIL %s_latency got done at %0d want 48", name, done_at); else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL %s_done_count got %0d want 1", name, done_cnt); else pass_cnt++;
        total_cnt++;
        if (!busy_ok) $display("FAIL %s_busy got wrong busy window want high k=0..48 only", name); else pass_cnt++;
        total_cnt++;
        if (!stable_ok) $display("FAIL %s_res_stable got res change before done want %h held", name, last_res); else pass_cnt++;
        total_cnt++;
        if (res !== exp_res) $display("FAIL %s_res got %h want %h", name, res, exp_res); else pass_cnt++;
        total_cnt++;
        if (dz !== exp_dz) $display("FAIL %s_dz got %b want %b", name, dz, exp_dz); else pass_cnt++;
        last_res = exp_res;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(32'h00028000, 32'h00010000, 32'h00014000, 1'b0, "pos_5_div_2", 1'b0);
        run_op(32'hFFFD8000, 32'h00010000, 32'hFFFEC000, 1'b0, "neg_5_div_2", 1'b0);
        run_op(32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0, "one_third", 1'b0);
        run_op(32'hFFFD8000, 32'hFFFF0000, 32'h00014000, 1'b0, "neg_neg", 1'b0);
        run_op(32'hFFFF8000, 32'h00018000, 32'hFFFFD556, 1'b0, "neg_third_trunc", 1'b0);
        run_op(32'h00000001, 32'h7FFFFFFF, 32'h00000000, 1'b0, "tiny_zero", 1'b0);
    endtask

    task automatic test_div_zero();
        run_op(32'h00028000, 32'h00000000, 32'h7FFFFFFF, 1'b1, "dz_pos", 1'b0);
        run_op(32'hFFFD8000, 32'h00000000, 32'h80000000, 1'b1, "dz_neg", 1'b0);
        run_op(32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, "dz_zero", 1'b0);
    endtask

    task automatic test_saturation();
        run_op(32'h7FFF8000, 32'h00004000, 32'h7FFFFFFF, 1'b0, "sat_pos", 1'b0);
        run_op(32'h80000000, 32'h00004000, 32'h80000000, 1'b0, "sat_neg", 1'b0);
        run_op(32'h80000000, 32'h00008000, 32'h80000000, 1'b0, "min_div_one", 1'b0);
        run_op(32'h80000000, 32'hFFFF8000, 32'h7FFFFFFF, 1'b0, "min_div_neg_one", 1'b0);
    endtask

    task automatic test_operand_change();
        run_op(32'h00028000, 32'h00010000, 32'h00014000, 1'b0, "scramble", 1'b1);
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        a     = 32'h00028000;
        b     = 32'h00010000;
        start = 1'b1;
        for (int k = 0; k <= 20; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (res !== 32'h0) $display("FAIL midrst_res got %h want 00000000", res); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (dz !== 1'b0) $display("FAIL midrst_dz got %b want 0", dz); else pass_cnt++;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        total_cnt++;
        if (done_cnt !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", done_cnt); else pass_cnt++;
        total_cnt++;
        if (res !== 32'h0) $display("FAIL midrst_res_after got %h want 00000000", res); else pass_cnt++;
        last_res = 32'h0;
        run_op(32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0, "after_rst", 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        test_reset();
        test_basic();
        test_div_zero();
        test_saturation();
        test_operand_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
